// File: rtl/frame_stream_tx.sv
// Replays a stored SIZE x SIZE frame from a 1-cycle-latency RAM as one
// contiguous row-major pixel burst with done/eol/busy/frame_done framing.
module frame_stream_tx #(
  parameter int WIDTH  = 8,
  parameter int SIZE   = 30,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [WIDTH-1:0]  rd_data_i,
  output logic [WIDTH-1:0]  grayscale_o,
  output logic              done_o,
  output logic              eol_o,
  output logic              busy_o,
  output logic              frame_done_o
);

  localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FINISH} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [CW-1:0]     row_q, row_d;
  logic [CW-1:0]     col_q, col_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;

  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              eol_p0_q, eol_p0_d;
  logic              vld_p1_q, vld_p1_d;
  logic              eol_p1_q, eol_p1_d;
  logic              vld_p2_q, vld_p2_d;
  logic              eol_p2_q, eol_p2_d;
  logic [WIDTH-1:0]  gray_p2_q, gray_p2_d;

  logic col_last, row_last;

  assign col_last = (col_q == LAST);
  assign row_last = (row_q == LAST);

  // Sequencer: counters hold the next address to issue; outputs are registered.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    row_d        = row_q;
    col_d        = col_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    rd_en_d      = 1'b0;
    rd_addr_d    = '0;
    eol_p0_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = READ;
          busy_d  = 1'b1;
        end
      end
      READ: begin
        rd_en_d   = 1'b1;
        rd_addr_d = cnt_q;
        eol_p0_d  = col_last;
        if (col_last) begin
          col_d = '0;
          if (row_last) begin
            row_d   = '0;
            cnt_d   = '0;
            state_d = DRAIN;
          end else begin
            row_d = row_q + CW'(1);
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end else begin
          col_d = col_q + CW'(1);
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        // Last pixel sits in the output stage with nothing behind it.
        if (vld_p2_q && !vld_p1_q) begin
          state_d      = FINISH;
          frame_done_d = 1'b1;
        end
      end
      FINISH: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage 1 spans the RAM latency; stage 2 captures the returned pixel.
  always_comb begin
    vld_p1_d  = rd_en_q;
    eol_p1_d  = eol_p0_q;
    vld_p2_d  = vld_p1_q;
    eol_p2_d  = eol_p1_q;
    gray_p2_d = vld_p1_q ? rd_data_i : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      row_q        <= '0;
      col_q        <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      eol_p0_q     <= 1'b0;
      vld_p1_q     <= 1'b0;
      eol_p1_q     <= 1'b0;
      vld_p2_q     <= 1'b0;
      eol_p2_q     <= 1'b0;
      gray_p2_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      row_q        <= row_d;
      col_q        <= col_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      eol_p0_q     <= eol_p0_d;
      vld_p1_q     <= vld_p1_d;
      eol_p1_q     <= eol_p1_d;
      vld_p2_q     <= vld_p2_d;
      eol_p2_q     <= eol_p2_d;
      gray_p2_q    <= gray_p2_d;
    end
  end

  assign rd_en_o      = rd_en_q;
  assign rd_addr_o    = rd_addr_q;
  assign grayscale_o  = gray_p2_q;
  assign done_o       = vld_p2_q;
  assign eol_o        = eol_p2_q;
  assign busy_o       = busy_q;
  assign frame_done_o = frame_done_q;

endmodule
